shift_gain_ctrl_48bit: RTL
==========================

Name: shift_gain_ctrl_48bit

Overview:
- Closed-loop controller that generates the 16-bit left-shift amount (scaled_coeff) consumed by the 48-to-16-bit gain/truncation stage of the DDC datapath.
- Monitors the same 48-bit signed accumulator stream that feeds the truncation stage and measures peak magnitude per window.
- Chooses the largest shift that keeps the top 16 bits free of overflow, leaving HEADROOM bits of margin.
- Attack (gain reduction) is immediate. Release (gain increase) is limited to +1 per window.

Parameters:
- WIN_LEN_LOG2, 10: window length = 2^WIN_LEN_LOG2 accepted samples.
- MAX_SHIFT, 32: upper clamp for scaled_coeff, legal range 0..47.
- HEADROOM, 1: guard bits subtracted from the computed shift.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- din_valid  in  1  sample strobe; only cycles with din_valid=1 are counted.
- din  in  48  signed two's-complement accumulator sample.
- freeze  in  1  when high, scaled_coeff holds its value and coeff_valid is suppressed.
- scaled_coeff  out  16  shift amount; bits [15:6] are always 0.
- coeff_valid  out  1  one-cycle pulse on each window evaluation that is not frozen.
- overflow_flag  out  1  high if the last completed window held a sample that overflows at the shift in effect.

Behaviour:
- Reset: scaled_coeff=0, coeff_valid=0, overflow_flag=0. Window counter, peak register, sticky overflow bit and all pipeline valids clear to 0. A reset mid-window discards the partial window; the next accepted sample is sample 0.
- Stage 1 (t+1): mag = |din|. din=0x8000_0000_0000 saturates to 0x7FFF_FFFF_FFFF. Per-sample overflow condition: mag >= 2^(47-scaled_coeff), evaluated against the current scaled_coeff; it ORs into the sticky overflow bit.
- Window counter: increments on each accepted sample and wraps from 2^WIN_LEN_LOG2-1 to 0. The sample at count 2^WIN_LEN_LOG2-1 closes the window.
- Stage 2 (t+2), window close: snapshot = max(peak, mag_last); peak<=0; sticky_ovf<=0; overflow_flag<=sticky_ovf OR ovf_last. Otherwise peak<=max(peak,mag) on valid samples.
- Stage 3 (t+3): lz = leading-zero count of the 48-bit snapshot, with lz=48 for zero. target = lz-1-HEADROOM, computed signed and clamped to 0..MAX_SHIFT.
- Stage 4 (t+4), update rule:
  - target < scaled_coeff: scaled_coeff<=target (attack).
  - target > scaled_coeff: scaled_coeff<=scaled_coeff+1 (release).
  - otherwise hold.
- coeff_valid pulses at t+4 on every evaluation, including hold; both are suppressed while freeze=1. freeze is sampled at t+4.
- Latency: window-closing sample accepted at cycle t, scaled_coeff changes at t+4.
- Throughput: din_valid may be high every cycle. Back-to-back window closes (WIN_LEN_LOG2=0) must still evaluate every sample.
- A new scaled_coeff takes effect for overflow checking from the cycle after it updates.
- din_valid=0 cycles do not advance the counter, the peak or the overflow logic; pipeline stages hold.

Optional Feature:
- Macro SGC_MANUAL_EN.
- Defined: adds inputs manual_en (1 bit) and manual_shift (6 bits).
  - While manual_en=1, scaled_coeff <= min(manual_shift, MAX_SHIFT) on the next cycle, every cycle; automatic updates and coeff_valid are suppressed; freeze is ignored.
  - Windows, the peak and overflow_flag keep running.
  - When manual_en falls, automatic control resumes from the manual value at the next window close.
- Not defined: these ports and this logic are absent; behaviour is as described above.

Test Plan:
- WIN_LEN_LOG2=4, reset, then din=0x0000_0000_1234 constantly valid (lz=35, target 33→32). Required: scaled_coeff steps 1,2,3… with one step per 16 samples, coeff_valid pulses 4 cycles after each 16th sample, and it saturates at 32.
- Reach scaled_coeff=10, then a window containing one sample 0x0400_0000_0000 (lz=5, target 3). Required: scaled_coeff=3 at t+4 in a single step, and overflow_flag=1 for that window (mag ≥ 2^37).
- A window of din=0x8000_0000_0000. Required: mag saturates, lz=1, target clamps to 0, scaled_coeff=0, overflow_flag=0 when the shift was already 0.
- freeze=1 across two window closes with target≠current. Required: scaled_coeff unchanged, no coeff_valid; after freeze drops, the next close updates normally.
- Assert rst at sample 9 of a window holding a large peak. Required: all outputs 0 next cycle, and the following 16 samples of zeros yield scaled_coeff=1 (release from 0).
- SGC_MANUAL_EN defined, MAX_SHIFT=32, manual_en=1, manual_shift=40. Required: scaled_coeff=32 the next cycle, held across window closes with no coeff_valid.

Source files
------------

// File: rtl/shift_gain_ctrl_48bit.sv
// shift_gain_ctrl_48bit: closed-loop shift controller for the 48-to-16-bit truncation stage.
// It tracks the peak magnitude of the 48-bit accumulator stream over each window and picks
// the largest left shift that still leaves HEADROOM guard bits. Gain reduction (attack) is
// immediate. Gain increase (release) is limited to +1 per window.
// Optional build macro SGC_MANUAL_EN adds a manual override (manual_en / manual_shift).
// Pipeline: sample accepted at t, magnitude at t+1, window peak at t+2, target at t+3,
// and scaled_coeff at t+4.
module shift_gain_ctrl_48bit #(
  parameter int WIN_LEN_LOG2 = 10,
  parameter int MAX_SHIFT    = 32,
  parameter int HEADROOM     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [47:0] din,
  input  logic        freeze,
`ifdef SGC_MANUAL_EN
  input  logic        manual_en,
  input  logic [5:0]  manual_shift,
`endif
  output logic [15:0] scaled_coeff,
  output logic        coeff_valid,
  output logic        overflow_flag
);

  // A zero-length counter is illegal, so keep at least one bit. With WIN_LEN_LOG2=0,
  // every sample closes its own window.
  localparam int CW = (WIN_LEN_LOG2 > 0) ? WIN_LEN_LOG2 : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_c;
  logic [47:0]   abs_c;
  logic [5:0]    thr_sh_c;
  logic          ovf_c;

  logic          v1_q, last1_q, ovf1_q;
  logic [47:0]   mag1_q;
  logic [47:0]   peak_q, snap2_q, peak_max_c;
  logic          sticky_q, v2_q, ovf_flag_q;
  logic          v3_q;
  logic [5:0]    tgt3_q, tgt_c;
  logic [5:0]    sc_q, sc_d;
  logic          cv_q, cv_d;

  // Stage-0 combinational work: saturated magnitude, per-sample overflow, and window position.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default first, so no latch can be inferred.
    abs_c    = din;
    thr_sh_c = 6'(47 - int'(sc_q));
    if (din[47]) begin
      // The most negative value has no positive twin, so it saturates.
      abs_c = (din == 48'h8000_0000_0000) ? 48'h7FFF_FFFF_FFFF : 48'(-din);
    end
    ovf_c  = (abs_c >> thr_sh_c) != 48'd0;
    last_c = (WIN_LEN_LOG2 == 0) ? 1'b1 : (cnt_q == CW'((1 << WIN_LEN_LOG2) - 1));
    cnt_d  = (WIN_LEN_LOG2 == 0) ? '0 : cnt_q + 1'b1;
  end

  // Window counter and stage 1 register: these advance only on accepted samples.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      ovf1_q  <= 1'b0;
      mag1_q  <= '0;
    end else begin
      v1_q <= din_valid;
      if (din_valid) begin
        cnt_q   <= cnt_d;
        last1_q <= last_c;
        ovf1_q  <= ovf_c;
        mag1_q  <= abs_c;
      end
    end
  end

  assign peak_max_c = (mag1_q > peak_q) ? mag1_q : peak_q;

  // Stage 2: update the running peak and the sticky overflow. Take a snapshot at window close.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      snap2_q    <= '0;
      sticky_q   <= 1'b0;
      v2_q       <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      v2_q <= v1_q & last1_q;
      if (v1_q) begin
        if (last1_q) begin
          snap2_q    <= peak_max_c;
          peak_q     <= '0;
          sticky_q   <= 1'b0;
          ovf_flag_q <= sticky_q | ovf1_q;
        end else begin
          peak_q   <= peak_max_c;
          sticky_q <= sticky_q | ovf1_q;
        end
      end
    end
  end

  // Leading-zero count of the snapshot, then clamp the shift target into 0..MAX_SHIFT.
  always_comb begin
    int lz;
    int t;
    lz = 48;
    for (int i = 0; i < 48; i++) begin
      if (snap2_q[i]) lz = 47 - i;
    end
    t = lz - 1 - HEADROOM;
    if (t < 0) t = 0;
    if (t > MAX_SHIFT) t = MAX_SHIFT;
    tgt_c = 6'(t);
  end

  // Stage 3: register the target for the update stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      tgt3_q <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) tgt3_q <= tgt_c;
    end
  end

  // Stage 4 next state: attack jumps straight to the target, and release steps by one.
  // Freeze or the manual override suppresses the update.
  always_comb begin
    sc_d = sc_q;
    cv_d = 1'b0;
    if (v3_q && !freeze) begin
      cv_d = 1'b1;
      if (tgt3_q < sc_q)      sc_d = tgt3_q;
      else if (tgt3_q > sc_q) sc_d = sc_q + 6'd1;
    end
`ifdef SGC_MANUAL_EN
    if (manual_en) begin
      cv_d = 1'b0;
      sc_d = (int'(manual_shift) > MAX_SHIFT) ? 6'(MAX_SHIFT) : manual_shift;
    end
`endif
  end

  // Stage 4 register: the shift in effect and the evaluation pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      cv_q <= 1'b0;
    end else begin
      sc_q <= sc_d;
      cv_q <= cv_d;
    end
  end

  assign scaled_coeff  = {10'd0, sc_q};
  assign coeff_valid   = cv_q;
  assign overflow_flag = ovf_flag_q;

endmodule
